// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue. Holds tagged instructions and captures operands
// broadcast on the CDB. The lowest-indexed fully-ready entry moves into a
// registered valid/ready output stage.
module wakeup_issue_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int TAG_WIDTH   = 6,
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [INSTR_WIDTH-1:0] enq_instr,
  input  logic                   enq_rs1_rdy,
  input  logic                   enq_rs2_rdy,
  input  logic [TAG_WIDTH-1:0]   enq_rs1_tag,
  input  logic [TAG_WIDTH-1:0]   enq_rs2_tag,
  input  logic [DATA_WIDTH-1:0]  enq_rs1_val,
  input  logic [DATA_WIDTH-1:0]  enq_rs2_val,
  input  logic [TAG_WIDTH-1:0]   enq_rd_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_WIDTH-1:0]   cdb_tag,
  input  logic [DATA_WIDTH-1:0]  cdb_data,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [INSTR_WIDTH-1:0] issue_instr,
  output logic [DATA_WIDTH-1:0]  issue_op1,
  output logic [DATA_WIDTH-1:0]  issue_op2,
  output logic [TAG_WIDTH-1:0]   issue_rd_tag,
  output logic [CNT_WIDTH-1:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int IDX_W = $clog2(DEPTH);

  // Entry array
  logic [DEPTH-1:0]       ent_vld;
  logic [DEPTH-1:0]       ent_rs1_rdy;
  logic [DEPTH-1:0]       ent_rs2_rdy;
  logic [INSTR_WIDTH-1:0] ent_instr   [DEPTH];
  logic [TAG_WIDTH-1:0]   ent_rd_tag  [DEPTH];
  logic [TAG_WIDTH-1:0]   ent_rs1_tag [DEPTH];
  logic [TAG_WIDTH-1:0]   ent_rs2_tag [DEPTH];
  logic [DATA_WIDTH-1:0]  ent_rs1_val [DEPTH];
  logic [DATA_WIDTH-1:0]  ent_rs2_val [DEPTH];

  logic [CNT_WIDTH-1:0]   count_q;

  // Output stage registers
  logic                   vld_p1;
  logic [INSTR_WIDTH-1:0] instr_p1;
  logic [DATA_WIDTH-1:0]  op1_p1;
  logic [DATA_WIDTH-1:0]  op2_p1;
  logic [TAG_WIDTH-1:0]   rd_tag_p1;

  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic                   enq_fire;
  logic                   load;
  logic                   byp_rs1_rdy;
  logic                   byp_rs2_rdy;
  logic [DATA_WIDTH-1:0]  byp_rs1_val;
  logic [DATA_WIDTH-1:0]  byp_rs2_val;

  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ready = !full;
  assign count     = count_q;

  // Lowest free slot for enqueue and lowest eligible entry for issue
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent_vld[i] && ent_rs1_rdy[i] && ent_rs2_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Handshakes and same-cycle CDB bypass into the enqueuing sources
  always_comb begin
    enq_fire    = enq_valid && enq_ready && free_found;
    load        = sel_found && (!vld_p1 || issue_ready);
    byp_rs1_rdy = enq_rs1_rdy || (cdb_valid && (cdb_tag == enq_rs1_tag));
    byp_rs2_rdy = enq_rs2_rdy || (cdb_valid && (cdb_tag == enq_rs2_tag));
    byp_rs1_val = enq_rs1_rdy ? enq_rs1_val : cdb_data;
    byp_rs2_val = enq_rs2_rdy ? enq_rs2_val : cdb_data;
  end

  // Entry valid bits, occupancy and output-stage valid
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      ent_vld <= '0;
      count_q <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (load)
        ent_vld[sel_idx] <= 1'b0;
      if (enq_fire)
        ent_vld[free_idx] <= 1'b1;
      vld_p1 <= load || (vld_p1 && !issue_ready);
      case ({enq_fire, load})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload capture on enqueue and operand wakeup from the CDB
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && (free_idx == IDX_W'(i))) begin
        ent_instr[i]   <= enq_instr;
        ent_rd_tag[i]  <= enq_rd_tag;
        ent_rs1_rdy[i] <= byp_rs1_rdy;
        ent_rs2_rdy[i] <= byp_rs2_rdy;
        ent_rs1_tag[i] <= enq_rs1_tag;
        ent_rs2_tag[i] <= enq_rs2_tag;
        ent_rs1_val[i] <= byp_rs1_val;
        ent_rs2_val[i] <= byp_rs2_val;
      end else if (ent_vld[i] && cdb_valid) begin
        if (!ent_rs1_rdy[i] && (ent_rs1_tag[i] == cdb_tag)) begin
          ent_rs1_rdy[i] <= 1'b1;
          ent_rs1_val[i] <= cdb_data;
        end
        if (!ent_rs2_rdy[i] && (ent_rs2_tag[i] == cdb_tag)) begin
          ent_rs2_rdy[i] <= 1'b1;
          ent_rs2_val[i] <= cdb_data;
        end
      end
    end
  end

  // Output stage payload: loads the selected entry, otherwise holds
  always_ff @(posedge clk) begin
    if (!resetn) begin
      instr_p1  <= '0;
      op1_p1    <= '0;
      op2_p1    <= '0;
      rd_tag_p1 <= '0;
    end else if (!flush && load) begin
      instr_p1  <= ent_instr[sel_idx];
      op1_p1    <= ent_rs1_val[sel_idx];
      op2_p1    <= ent_rs2_val[sel_idx];
      rd_tag_p1 <= ent_rd_tag[sel_idx];
    end
  end

  assign issue_valid  = vld_p1;
  assign issue_instr  = instr_p1;
  assign issue_op1    = op1_p1;
  assign issue_op2    = op2_p1;
  assign issue_rd_tag = rd_tag_p1;

endmodule
